// File: rtl/i2c_temp_reader.sv
// I2C master that polls an ADT7420 and returns its 16-bit raw temperature word.
// Latency: POLL_CYCLES idle clks, then one 27-pulse read (116 quarter-bit ticks) plus one DONE clk.
// Backpressure: none; dout is a latched register with a one-cycle dout_valid strobe, no ready.
module i2c_temp_reader #(
  parameter int         CLK_HZ      = 100_000_000,
  parameter int         SCL_HZ      = 200_000,
  parameter logic [6:0] DEV_ADDR    = 7'h4B,
  parameter int         POLL_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        scl,
  inout  wire         sda,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        nack_err,
  output logic        busy
);

  localparam int         QDIV      = CLK_HZ / (4 * SCL_HZ);
  localparam int         DIV_W     = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int         POLL_W    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [7:0] ADDR_BYTE = {DEV_ADDR, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_RD_MSB,
    S_M_ACK, S_RD_LSB, S_M_NACK, S_STOP, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [POLL_W-1:0]  poll_q, poll_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [1:0]         qph_q, qph_d;
  logic [2:0]         bit_q, bit_d;
  logic [15:0]        shreg_q, shreg_d;
  logic               ack_ok_q, ack_ok_d;
  logic               scl_low_q, scl_low_d;
  logic               sda_low_q, sda_low_d;
  logic [15:0]        dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               nack_err_q, nack_err_d;
  logic               busy_q, busy_d;
  logic               sda_meta_q, sda_sync_q;
  logic               tick;

  // Open-drain pads: only ever pull low or release.
  assign scl        = scl_low_q ? 1'b0 : 1'bz;
  assign sda        = sda_low_q ? 1'b0 : 1'bz;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign nack_err   = nack_err_q;
  assign busy       = busy_q;

  // Next-state logic: poll timer in IDLE, quarter-bit sequencer elsewhere.
  always_comb begin
    state_d      = state_q;
    poll_d       = poll_q;
    div_d        = div_q;
    qph_d        = qph_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    ack_ok_d     = ack_ok_q;
    scl_low_d    = scl_low_q;
    sda_low_d    = sda_low_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    nack_err_d   = nack_err_q;
    tick         = (div_q == DIV_W'(QDIV - 1));

    case (state_q)
      S_IDLE: begin
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
        div_d     = '0;
        qph_d     = 2'd0;
        ack_ok_d  = 1'b0;
        if (poll_q == POLL_W'(POLL_CYCLES - 1)) begin
          poll_d  = '0;
          state_d = S_START;
        end else begin
          poll_d = poll_q + 1'b1;
        end
      end

      S_DONE: begin
        // Only a fully ACKed read publishes a new word.
        if (ack_ok_q) begin
          dout_d       = shreg_q;
          dout_valid_d = 1'b1;
          nack_err_d   = 1'b0;
        end
        poll_d  = '0;
        state_d = S_IDLE;
      end

      default: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          qph_d = qph_q + 2'd1;
          case (qph_q)
            2'd0: begin
              // SCL low: set up the next SDA level.
              if (state_q != S_START) scl_low_d = 1'b1;
              case (state_q)
                S_ADDR:  sda_low_d = ~ADDR_BYTE[bit_q];
                S_M_ACK: sda_low_d = 1'b1;
                S_STOP:  sda_low_d = 1'b1;
                default: sda_low_d = 1'b0;
              endcase
            end
            2'd1: scl_low_d = 1'b0;
            2'd2: begin
              // SCL high: sample, or make the START/STOP edge on SDA.
              case (state_q)
                S_START:    sda_low_d = 1'b1;
                S_STOP:     sda_low_d = 1'b0;
                S_ADDR_ACK: ack_ok_d  = ~sda_sync_q;
                S_RD_MSB,
                S_RD_LSB:   shreg_d   = {shreg_q[14:0], sda_sync_q};
                default:    ;
              endcase
            end
            default: begin
              if (state_q != S_STOP) scl_low_d = 1'b1;
              case (state_q)
                S_START: begin
                  state_d = S_ADDR;
                  bit_d   = 3'd7;
                end
                S_ADDR: begin
                  if (bit_q == 3'd0) state_d = S_ADDR_ACK;
                  else               bit_d   = bit_q - 3'd1;
                end
                S_ADDR_ACK: begin
                  if (ack_ok_q) begin
                    state_d = S_RD_MSB;
                    bit_d   = 3'd7;
                  end else begin
                    state_d    = S_STOP;
                    nack_err_d = 1'b1;
                  end
                end
                S_RD_MSB: begin
                  if (bit_q == 3'd0) state_d = S_M_ACK;
                  else               bit_d   = bit_q - 3'd1;
                end
                S_M_ACK: begin
                  state_d = S_RD_LSB;
                  bit_d   = 3'd7;
                end
                S_RD_LSB: begin
                  if (bit_q == 3'd0) state_d = S_M_NACK;
                  else               bit_d   = bit_q - 3'd1;
                end
                S_M_NACK: state_d = S_STOP;
                default:  state_d = S_DONE;
              endcase
            end
          endcase
        end
      end
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // State and registered outputs; reset releases both bus lines at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      poll_q       <= '0;
      div_q        <= '0;
      qph_q        <= 2'd0;
      bit_q        <= 3'd0;
      shreg_q      <= 16'h0000;
      ack_ok_q     <= 1'b0;
      scl_low_q    <= 1'b0;
      sda_low_q    <= 1'b0;
      dout_q       <= 16'h0000;
      dout_valid_q <= 1'b0;
      nack_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      sda_meta_q   <= 1'b1;
      sda_sync_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      poll_q       <= poll_d;
      div_q        <= div_d;
      qph_q        <= qph_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      ack_ok_q     <= ack_ok_d;
      scl_low_q    <= scl_low_d;
      sda_low_q    <= sda_low_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      nack_err_q   <= nack_err_d;
      busy_q       <= busy_d;
      sda_meta_q   <= sda;
      sda_sync_q   <= sda_meta_q;
    end
  end

endmodule

// File: tb/tb_i2c_temp_reader.sv
// Bench for i2c_temp_reader: behavioural ADT7420 slave, bus protocol monitor, dout scoreboard.
// Latency: each transaction is awaited against a cycle budget.
// Backpressure: none on dout; the bench only observes the strobe.
module tb_i2c_temp_reader;

  localparam int CLK_HZ  = 100_000_000;
  localparam int SCL_HZ  = 12_500_000;
  localparam int POLL    = 100;
  localparam int QDIV    = CLK_HZ / (4 * SCL_HZ);
  localparam int PERIOD  = 4 * QDIV * (1 + 27 + 1) + 1 + POLL;

  logic        clk;
  logic        rst_n;
  wire         scl_w;
  wire         sda_w;
  logic [15:0] dout;
  logic        dout_valid;
  logic        nack_err;
  logic        busy;

  pullup (scl_w);
  pullup (sda_w);

  i2c_temp_reader #(
    .CLK_HZ(CLK_HZ), .SCL_HZ(SCL_HZ), .DEV_ADDR(7'h4B), .POLL_CYCLES(POLL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl_w), .sda(sda_w),
    .dout(dout), .dout_valid(dout_valid), .nack_err(nack_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboards: pulse count expected at each STOP, word expected at each dout_valid.
  int          exp_pulse_q[$];
  logic [15:0] exp_dout_q[$];

  // Slave response for the next transaction.
  logic       s_ack = 1'b1;
  logic [7:0] s_msb = 8'h00;
  logic [7:0] s_lsb = 8'h00;
  logic       slave_en = 1'b1;
  logic       s_low = 1'b0;
  assign sda_w = (s_low && slave_en) ? 1'b0 : 1'bz;

  typedef enum {SL_IDLE, SL_ADDR, SL_AACK, SL_DATA, SL_MACK} sl_t;
  sl_t        sl = SL_IDLE;
  int         bitc = 0;
  logic [7:0] sh = 8'h00;
  logic [7:0] cur = 8'h00;
  logic       second = 1'b0;

  logic       scl_p = 1'b1, sda_p = 1'b1, valid_p = 1'b0;
  logic       mon_en = 1'b1;
  logic       in_txn = 1'b0;
  logic       high_seen = 1'b0;
  int         pulse_cnt = 0;
  int         stop_cnt = 0;
  int         valid_cnt = 0;
  longint     cyc = 0;
  longint     last_start = 0, prev_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave, protocol monitor and output scoreboard, all sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      sl = SL_IDLE; s_low = 1'b0; in_txn = 1'b0; high_seen = 1'b0; pulse_cnt = 0;
    end else begin
      if (scl_p && scl_w && sda_p && !sda_w) begin
        // START
        if (mon_en) begin
          check("start_outside_txn", in_txn, 1'b0);
          check("busy_at_start", busy, 1'b1);
        end
        in_txn = 1'b1; high_seen = 1'b0; pulse_cnt = 0;
        prev_start = last_start; last_start = cyc;
        sl = SL_ADDR; bitc = 0; sh = 8'h00; s_low = 1'b0;
      end else if (scl_p && scl_w && !sda_p && sda_w) begin
        // STOP
        if (mon_en) begin
          check("stop_inside_txn", in_txn, 1'b1);
          check("stop_has_exp", exp_pulse_q.size() != 0, 1'b1);
          if (exp_pulse_q.size() != 0) check("scl_pulses", pulse_cnt, exp_pulse_q.pop_front());
        end
        in_txn = 1'b0; stop_cnt++;
        sl = SL_IDLE; s_low = 1'b0;
      end else if (!scl_p && scl_w) begin
        high_seen = 1'b1;
        if (sl == SL_ADDR) begin
          sh = {sh[6:0], sda_w}; bitc++;
        end else if (sl == SL_MACK && mon_en) begin
          check(second ? "master_nack_lsb" : "master_ack_msb", sda_w, second);
        end
      end else if (scl_p && !scl_w) begin
        if (in_txn && high_seen) pulse_cnt++;
        high_seen = 1'b0;
        case (sl)
          SL_ADDR: if (bitc == 8) begin
            if (mon_en) check("addr_byte", sh, 8'h97);
            sl = SL_AACK; s_low = s_ack && (sh == 8'h97);
          end
          SL_AACK: if (s_low) begin
            sl = SL_DATA; cur = s_msb; second = 1'b0; bitc = 0; s_low = ~s_msb[7];
          end else begin
            sl = SL_IDLE; s_low = 1'b0;
          end
          SL_DATA: begin
            bitc++;
            if (bitc == 8) begin sl = SL_MACK; s_low = 1'b0; end
            else s_low = ~cur[7 - bitc];
          end
          SL_MACK: if (!second) begin
            sl = SL_DATA; cur = s_lsb; second = 1'b1; bitc = 0; s_low = ~s_lsb[7];
          end else begin
            sl = SL_IDLE; s_low = 1'b0;
          end
          default: ;
        endcase
      end
      if (dout_valid) begin
        check("valid_one_cycle", valid_p, 1'b0);
        check("valid_has_exp", exp_dout_q.size() != 0, 1'b1);
        if (exp_dout_q.size() != 0) check("dout", dout, exp_dout_q.pop_front());
        check("nack_clear_on_valid", nack_err, 1'b0);
        valid_cnt++;
      end
    end
    scl_p = scl_w; sda_p = sda_w; valid_p = dout_valid;
  end

  // One polled read: program the slave, post expectations, wait for STOP and DONE.
  task automatic run_txn(input logic ack, input logic [7:0] msb, input logic [7:0] lsb);
    int s0;
    int v0;
    bit seen;
    s0 = stop_cnt; v0 = valid_cnt; seen = 1'b0;
    s_ack = ack; s_msb = msb; s_lsb = lsb;
    exp_pulse_q.push_back(ack ? 27 : 9);
    if (ack) exp_dout_q.push_back({msb, lsb});
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (stop_cnt != s0) seen = 1'b1;
    end
    check("txn_completed", seen, 1'b1);
    repeat (4) @(negedge clk);
    check("busy_after_stop", busy, 1'b0);
    check("valid_count", valid_cnt, v0 + (ack ? 1 : 0));
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_scl", scl_w, 1'b1);
    check("rst_sda", sda_w, 1'b1);
    check("rst_dout", dout, 16'h0000);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_nack", nack_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    run_txn(1'b1, 8'h0C, 8'h80);              // 25.0 C
    run_txn(1'b0, 8'h00, 8'h00);              // address NACK
    check("nack_err_set", nack_err, 1'b1);
    check("dout_held_nack", dout, 16'h0C80);
    run_txn(1'b1, 8'hE4, 8'h80);              // -55 C, clears nack_err
    check("nack_err_cleared", nack_err, 1'b0);
    run_txn(1'b0, 8'h00, 8'h00);
    check("nack_err_set2", nack_err, 1'b1);

    // Abort a read partway through the MSB byte.
    begin
      bit hit;
      hit = 1'b0;
      s_ack = 1'b1; s_msb = 8'h55; s_lsb = 8'hAA;
      for (int i = 0; i < 3000 && !hit; i++) begin
        @(negedge clk);
        if (in_txn && pulse_cnt >= 12 && scl_w == 1'b0) hit = 1'b1;
      end
      check("reached_mid_byte", hit, 1'b1);
      slave_en = 1'b0; mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_scl", scl_w, 1'b1);
      check("midrst_sda", sda_w, 1'b1);
      check("midrst_dout", dout, 16'h0000);
      check("midrst_valid", dout_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_nack", nack_err, 1'b0);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      slave_en = 1'b1; mon_en = 1'b1;
    end

    // Back-to-back polling: two readings and the START-to-START spacing.
    run_txn(1'b1, 8'h0C, 8'h80);
    run_txn(1'b1, 8'h0D, 8'h00);
    check("poll_gap", 32'(last_start - prev_start), PERIOD);
    check("dout_final", dout, 16'h0D00);
    check("scoreboard_drained", exp_dout_q.size() + exp_pulse_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
